// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI4 read data mover.
// Beat geometry is fixed at 64 bytes; bursts never cross a 4 KB page.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_e;

  localparam int BEAT_BYTES = 64;
  localparam int PAGE_BYTES = 4096;
  localparam int PAGE_BEATS = PAGE_BYTES / BEAT_BYTES;
  localparam int BUF_DEPTH  = 4096;
  localparam int BUF_AW     = 12;
  localparam int BEAT_CNT_W = 13;

  localparam logic [2:0] AXI_ARSIZE     = 3'd6;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Beats in the next burst: limited by what is left, the burst cap and the page end.
  function automatic logic [BEAT_CNT_W-1:0] burst_beats(
    input logic [5:0]            page_beat,
    input logic [BEAT_CNT_W-1:0] remaining,
    input logic [BEAT_CNT_W-1:0] max_beats
  );
    logic [BEAT_CNT_W-1:0] to_page;
    logic [BEAT_CNT_W-1:0] len;
    to_page = BEAT_CNT_W'(PAGE_BEATS) - {7'd0, page_beat};
    len     = remaining;
    if (max_beats < len) len = max_beats;
    if (to_page < len)   len = to_page;
    return len;
  endfunction

endpackage

// File: rtl/data_untrimmer.sv
// Splits a packed bus of DATA_COUNT lanes and keeps the low OUT_WIDTH bits of each.
// Purely combinational; no backpressure.
module data_untrimmer #(
  parameter int IN_WIDTH   = 64,
  parameter int OUT_WIDTH  = 39,
  parameter int DATA_COUNT = 8
) (
  input  logic [IN_WIDTH*DATA_COUNT-1:0]  in_dat,
  output logic [OUT_WIDTH*DATA_COUNT-1:0] out_dat
);

  for (genvar i = 0; i < DATA_COUNT; i++) begin : g_lane
    assign out_dat[i*OUT_WIDTH +: OUT_WIDTH] = in_dat[i*IN_WIDTH +: OUT_WIDTH];
    if (OUT_WIDTH < IN_WIDTH) begin : g_drop
      // Upper lane bits carry no payload and are deliberately dropped.
      logic unused_hi;
      assign unused_hi = ^in_dat[i*IN_WIDTH+OUT_WIDTH +: IN_WIDTH-OUT_WIDTH];
    end
  end

endmodule

// File: rtl/axi_data_rd_top.sv
// AXI4 read mover: splits a region into 4 KB-safe INCR bursts and writes one unpacked word per beat.
// AR one cycle after start/rlast; buffer write one cycle after each R handshake; rready only in S_R.
module axi_data_rd_top
  import axi_rd_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH      = 64,
  parameter int AXI_DATA_WIDTH      = 512,
  parameter int AXI_XFER_SIZE_WIDTH = 32,
  parameter int DATA_WIDTH          = 39,
  parameter int MAX_BURST_BEATS     = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic                           m_axi_arvalid,
  input  logic                           m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                     m_axi_arlen,
  input  logic                           m_axi_rvalid,
  output logic                           m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic                           m_axi_rlast,
  input  logic                           i_axird_start,
  output logic                           o_axird_done,
  input  logic [AXI_ADDR_WIDTH-1:0]      data_ptr,
  input  logic [AXI_XFER_SIZE_WIDTH-1:0] data_size_bytes,
  output logic [BUF_AW-1:0]              o_axird_wraddr,
  output logic [8*DATA_WIDTH-1:0]        o_axird_wrdata,
  output logic                           o_axird_wren
);

  localparam int LANE_W = AXI_DATA_WIDTH / 8;
  localparam int SZW    = AXI_XFER_SIZE_WIDTH + 1;
  localparam logic [BEAT_CNT_W-1:0] MAX_BEATS = BEAT_CNT_W'(MAX_BURST_BEATS);

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]                arlen_q, arlen_d;
  logic [BEAT_CNT_W-1:0]     beats_left_q, beats_left_d;
  logic [BUF_AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [BUF_AW-1:0]         wraddr_q, wraddr_d;
  logic [8*DATA_WIDTH-1:0]   wrdata_q, wrdata_d;
  logic                      wren_q, wren_d;
  logic [8*DATA_WIDTH-1:0]   unpacked;

  data_untrimmer #(
    .IN_WIDTH  (LANE_W),
    .OUT_WIDTH (DATA_WIDTH),
    .DATA_COUNT(8)
  ) u_untrim (
    .in_dat (m_axi_rdata),
    .out_dat(unpacked)
  );

  // Beat count rounds a partial final beat up and is clamped to the buffer depth.
  logic [SZW-1:0]        size_round;
  logic [SZW-1:0]        total_raw;
  logic [BEAT_CNT_W-1:0] total_beats;
  assign size_round  = {1'b0, data_size_bytes} + SZW'(BEAT_BYTES - 1);
  assign total_raw   = size_round >> 6;
  assign total_beats = (total_raw > SZW'(BUF_DEPTH)) ? BEAT_CNT_W'(BUF_DEPTH)
                                                     : total_raw[BEAT_CNT_W-1:0];

  logic                      start_go, ar_hs, r_hs, r_last_hs;
  logic [BEAT_CNT_W-1:0]     beats_after;
  logic [14:0]               burst_bytes;
  logic [AXI_ADDR_WIDTH-1:0] next_addr;
  logic [BEAT_CNT_W-1:0]     start_len, next_len;

  assign start_go    = (state_q == S_IDLE) && i_axird_start && (total_beats != '0);
  assign ar_hs       = m_axi_arvalid && m_axi_arready;
  assign r_hs        = m_axi_rvalid && m_axi_rready;
  assign r_last_hs   = r_hs && m_axi_rlast;
  assign beats_after = (r_hs && beats_left_q != '0) ? beats_left_q - BEAT_CNT_W'(1) : beats_left_q;
  assign burst_bytes = {({1'b0, arlen_q} + 9'd1), 6'd0};
  assign next_addr   = araddr_q + AXI_ADDR_WIDTH'(burst_bytes);
  assign start_len   = burst_beats(data_ptr[11:6], total_beats, MAX_BEATS);
  assign next_len    = burst_beats(next_addr[11:6], beats_after, MAX_BEATS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_go) state_d = S_AR;
      S_AR:    if (ar_hs) state_d = S_R;
      S_R:     if (r_last_hs) state_d = (beats_after != '0) ? S_AR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_axi_arvalid = (state_q == S_AR);
    m_axi_rready  = (state_q == S_R);
    o_axird_done  = (state_q == S_IDLE);
  end

  always_comb begin
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    beats_left_d = beats_left_q;
    wr_ptr_d     = wr_ptr_q;
    wraddr_d     = wraddr_q;
    wrdata_d     = wrdata_q;
    wren_d       = r_hs;
    if (start_go) begin
      araddr_d     = data_ptr;
      arlen_d      = 8'(start_len - BEAT_CNT_W'(1));
      beats_left_d = total_beats;
      wr_ptr_d     = '0;
    end
    if (r_hs) begin
      beats_left_d = beats_after;
      wr_ptr_d     = wr_ptr_q + BUF_AW'(1);
      wraddr_d     = wr_ptr_q;
      wrdata_d     = unpacked;
    end
    // The next burst's address and length are ready when its AR goes out.
    if (r_last_hs && beats_after != '0) begin
      araddr_d = next_addr;
      arlen_d  = 8'(next_len - BEAT_CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_q     <= '0;
      arlen_q      <= '0;
      beats_left_q <= '0;
      wr_ptr_q     <= '0;
      wraddr_q     <= '0;
      wrdata_q     <= '0;
      wren_q       <= 1'b0;
    end else begin
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      beats_left_q <= beats_left_d;
      wr_ptr_q     <= wr_ptr_d;
      wraddr_q     <= wraddr_d;
      wrdata_q     <= wrdata_d;
      wren_q       <= wren_d;
    end
  end

  assign m_axi_araddr   = araddr_q;
  assign m_axi_arlen    = arlen_q;
  assign o_axird_wraddr = wraddr_q;
  assign o_axird_wrdata = wrdata_q;
  assign o_axird_wren   = wren_q;

endmodule

// File: tb/tb_axi_data_rd_top.sv
// Scoreboard bench for axi_data_rd_top: an AXI read slave model feeds data,
// expected AR requests and buffer writes are queued at start and popped as the DUT emits them.
`timescale 1ns/1ps
module tb_axi_data_rd_top;

  localparam int DWID = 39;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         m_axi_arvalid;
  logic         m_axi_arready = 1'b0;
  logic [63:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic         m_axi_rvalid = 1'b0;
  logic         m_axi_rready;
  logic [511:0] m_axi_rdata = '0;
  logic         m_axi_rlast = 1'b0;
  logic         i_axird_start = 1'b0;
  logic         o_axird_done;
  logic [63:0]  data_ptr = '0;
  logic [31:0]  data_size_bytes = '0;
  logic [11:0]  o_axird_wraddr;
  logic [311:0] o_axird_wrdata;
  logic         o_axird_wren;

  axi_data_rd_top dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arlen    (m_axi_arlen),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rlast    (m_axi_rlast),
    .i_axird_start  (i_axird_start),
    .o_axird_done   (o_axird_done),
    .data_ptr       (data_ptr),
    .data_size_bytes(data_size_bytes),
    .o_axird_wraddr (o_axird_wraddr),
    .o_axird_wrdata (o_axird_wrdata),
    .o_axird_wren   (o_axird_wren)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [11:0] a; logic [311:0] d; } wr_t;
  ar_t exp_ar[$];
  wr_t exp_wr[$];
  ar_t e;
  wr_t w;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave configuration and bookkeeping
  int   ar_delay = 0;
  int   rv_pct = 100;
  bit   pat_mode = 1'b0;
  int   cyc = 0;
  int   last_rlast_cyc = -1;
  int   last_wren_cyc = -1;
  int   done_rise_cyc = -1;
  int   wren_cnt = 0;
  int   arvalid_cnt = 0;
  bit   r_hs_now = 1'b0;
  logic hs_reg;
  logic done_prev = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) hs_reg <= 1'b0;
    else        hs_reg <= r_hs_now;

  function automatic logic [511:0] beat_data(input logic [63:0] a);
    logic [511:0] d;
    for (int i = 0; i < 8; i++)
      d[i*64 +: 64] = pat_mode ? (64'hFFFF_FF80_0000_0000 | 64'(i)) : {25'h1F0F0F0, a[31:0], 7'(i)};
    return d;
  endfunction

  function automatic logic [311:0] exp_word(input logic [63:0] a);
    logic [311:0] x;
    for (int i = 0; i < 8; i++)
      x[i*DWID +: DWID] = pat_mode ? 39'(i) : {a[31:0], 7'(i)};
    return x;
  endfunction

  // AXI read slave: one outstanding burst, optional AR delay and random rvalid.
  int          s_st = 0, s_beat = 0, s_wait = 0;
  logic [63:0] s_addr, seen_addr;
  logic [7:0]  s_len, seen_len;
  bit          s_seen = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      r_hs_now = 1'b0;
      if (!rst_n) begin
        s_st = 0; s_wait = 0; s_seen = 1'b0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      end else if (s_st == 0) begin
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        if (m_axi_arvalid) begin
          if (!s_seen) begin
            s_seen = 1'b1; seen_addr = m_axi_araddr; seen_len = m_axi_arlen;
          end else begin
            check_val("ar_hold_addr", m_axi_araddr, seen_addr);
            check_val("ar_hold_len", m_axi_arlen, seen_len);
          end
          if (s_wait >= ar_delay) begin
            m_axi_arready = 1'b1;
            s_addr = m_axi_araddr; s_len = m_axi_arlen;
            s_st = 1; s_beat = 0; s_wait = 0; s_seen = 1'b0;
            check_val("ar_expected", exp_ar.size() != 0, 1);
            if (exp_ar.size() != 0) begin
              e = exp_ar.pop_front();
              check_val("araddr", m_axi_araddr, e.addr);
              check_val("arlen", m_axi_arlen, e.len);
            end
          end else s_wait++;
        end
      end else begin
        m_axi_arready = 1'b0;
        m_axi_rvalid  = ($urandom_range(99) < rv_pct);
        m_axi_rlast   = (s_beat == int'(s_len));
        m_axi_rdata   = beat_data(s_addr + 64'(s_beat) * 64);
        if (m_axi_rvalid && m_axi_rready) begin
          r_hs_now = 1'b1;
          if (m_axi_rlast) begin
            last_rlast_cyc = cyc;
            s_st = 0;
          end
          s_beat++;
        end
      end
    end
  end

  // Buffer-write monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_val("wren_after_r", o_axird_wren, hs_reg);
        if (o_axird_wren) begin
          check_val("wr_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            check_val("wraddr", o_axird_wraddr, w.a);
            check_val("wrdata", o_axird_wrdata, w.d);
          end
          last_wren_cyc = cyc;
          wren_cnt++;
        end
        if (m_axi_arvalid) arvalid_cnt++;
        if (o_axird_done && !done_prev) done_rise_cyc = cyc;
        done_prev = o_axird_done;
      end
    end
  end

  task automatic prep(input logic [63:0] ptr, input logic [31:0] size);
    int rem, len, pg, nb;
    logic [63:0] a;
    nb = int'((64'(size) + 63) / 64);
    if (nb > 4096) nb = 4096;
    rem = nb;
    a = ptr;
    while (rem > 0) begin
      pg  = (4096 - int'(a[11:0])) / 64;
      len = rem;
      if (len > 64) len = 64;
      if (len > pg) len = pg;
      exp_ar.push_back('{addr: a, len: 8'(len - 1)});
      a   = a + 64'(len) * 64;
      rem = rem - len;
    end
    for (int j = 0; j < nb; j++)
      exp_wr.push_back('{a: 12'(j), d: exp_word(ptr + 64'(j) * 64)});
  endtask

  task automatic pulse_start(input logic [63:0] ptr, input logic [31:0] size);
    @(negedge clk);
    data_ptr = ptr; data_size_bytes = size; i_axird_start = 1'b1;
    @(negedge clk);
    i_axird_start = 1'b0;
    data_ptr = 64'hDEAD_BEEF_0000_0000; data_size_bytes = 32'd64;
  endtask

  task automatic run_xfer(input logic [63:0] ptr, input logic [31:0] size, input int ard,
                          input int rvp, input bit mode, input bit poke);
    int guard;
    ar_delay = ard; rv_pct = rvp; pat_mode = mode;
    prep(ptr, size);
    pulse_start(ptr, size);
    check_val("busy_after_start", o_axird_done, 0);
    check_val("arvalid_after_start", m_axi_arvalid, 1);
    guard = 0;
    while (!(o_axird_done && exp_wr.size() == 0) && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (poke && guard == 12) begin
        check_val("busy_at_poke", o_axird_done, 0);
        data_ptr = 64'h7000; data_size_bytes = 32'd4096; i_axird_start = 1'b1;
      end else i_axird_start = 1'b0;
    end
    check_val("xfer_in_time", guard < 20000, 1);
    repeat (3) @(negedge clk);
    check_val("ar_left", exp_ar.size(), 0);
    check_val("wr_left", exp_wr.size(), 0);
    check_val("done_after_rlast", done_rise_cyc, last_rlast_cyc + 1);
    check_val("last_wren_after_rlast", last_wren_cyc, last_rlast_cyc + 1);
    check_val("done_idle", o_axird_done, 1);
  endtask

  initial begin
    int guard;
    repeat (2) @(negedge clk);
    check_val("rst_done", o_axird_done, 1);
    check_val("rst_arvalid", m_axi_arvalid, 0);
    check_val("rst_rready", m_axi_rready, 0);
    check_val("rst_wren", o_axird_wren, 0);
    check_val("rst_araddr", m_axi_araddr, 0);
    check_val("rst_arlen", m_axi_arlen, 0);
    check_val("rst_wraddr", o_axird_wraddr, 0);
    check_val("rst_wrdata", o_axird_wrdata, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(64'h1000, 32'd256,  0, 100, 1'b0, 1'b0);
    run_xfer(64'h0,    32'd8192, 0, 100, 1'b0, 1'b0);
    run_xfer(64'h0F80, 32'd256,  0, 100, 1'b0, 1'b0);
    run_xfer(64'h4000, 32'd100,  0, 100, 1'b0, 1'b0);

    arvalid_cnt = 0;
    pulse_start(64'h8000, 32'd0);
    repeat (20) begin
      @(negedge clk);
      check_val("zero_done", o_axird_done, 1);
    end
    check_val("zero_no_ar", arvalid_cnt, 0);

    run_xfer(64'h5000, 32'd512, 5, 50, 1'b1, 1'b1);
    run_xfer(64'h6FC0, 32'd640, 2, 60, 1'b0, 1'b0);

    // Async reset in the middle of a read burst
    ar_delay = 0; rv_pct = 100; pat_mode = 1'b0;
    prep(64'h3000, 32'd4096);
    wren_cnt = 0;
    pulse_start(64'h3000, 32'd4096);
    guard = 0;
    while (wren_cnt < 5 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check_val("reach_mid_burst", guard < 1000, 1);
    check_val("mid_rready", m_axi_rready, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_wren", o_axird_wren, 0);
    check_val("arst_arvalid", m_axi_arvalid, 0);
    check_val("arst_rready", m_axi_rready, 0);
    check_val("arst_done", o_axird_done, 1);
    exp_ar.delete();
    exp_wr.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    run_xfer(64'h2000, 32'd128, 0, 100, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
